// File: rtl/rsfq_dfft_bank_if.sv
// Bundle for the RSFQ DFFT bank: transition-encoded data/clock in, outputs and sticky error flags out.
// Latency: wires only; all timing lives in the bank itself.
// Backpressure: none; the producer watches ready, and overflowing pulses are dropped and flagged.
interface rsfq_dfft_bank_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic [N-1:0]     a;
  logic             rclk;
  logic [N-1:0]     q;
  logic             ready;
  logic [N-1:0]     hold_err;
  logic [N-1:0]     ovf;
  logic [CNT_W-1:0] err_count;

  modport master (
    output a, rclk,
    input  q, ready, hold_err, ovf, err_count
  );

  modport slave (
    input  a, rclk,
    output q, ready, hold_err, ovf, err_count
  );
endinterface

// File: rtl/rsfq_dfft_bank.sv
// N-channel RSFQ toggle-output DFF bank emulated on one fast clock, with multi-flux storage and hold checks.
// Latency: q toggles on the same clk edge that samples the rclk transition (visible 1 cycle after it is driven).
// Backpressure: none; pulses before ready are ignored, pulses beyond DEPTH are dropped and raise ovf.
module rsfq_dfft_bank #(
  parameter int N          = 4,
  parameter int DEPTH      = 1,
  parameter int BEGIN_CYC  = 8,
  parameter int HOLD_EMPTY = 3,
  parameter int HOLD_FULL  = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  rsfq_dfft_bank_if.slave   bus
);

  localparam int HOLD_MAX = (HOLD_EMPTY > HOLD_FULL) ? HOLD_EMPTY : HOLD_FULL;
  localparam int SC_W     = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int C_W      = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
  localparam int I_W      = (BEGIN_CYC < 1) ? 1 : $clog2(BEGIN_CYC + 1);
  localparam int E_W      = $clog2(2 * N + 1);
  localparam int S_W      = CNT_W + E_W + 1;

  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(HOLD_MAX);
  localparam logic [SC_W-1:0] THR_E   = SC_W'(HOLD_EMPTY);
  localparam logic [SC_W-1:0] THR_F   = SC_W'(HOLD_FULL);
  localparam logic [C_W-1:0]  DEPTH_C = C_W'(DEPTH);

  // Registered state
  logic [N-1:0]     a_d;
  logic             rclk_d;
  logic [I_W-1:0]   init_cnt;
  logic             ready_r;
  logic [SC_W-1:0]  since_c;
  logic [C_W-1:0]   cnt [N];
  logic [N-1:0]     q_r;
  logic [N-1:0]     hold_err_r;
  logic [N-1:0]     ovf_r;
  logic [CNT_W-1:0] err_r;

  // Per-cycle decode
  logic [N-1:0]     pa;
  logic             pc;
  logic [SC_W-1:0]  eff_since;
  logic [N-1:0]     rel;
  logic [N-1:0]     herr;
  logic [N-1:0]     drop;
  logic [C_W-1:0]   post_rel [N];
  logic [C_W-1:0]   cnt_nxt [N];
  logic [E_W-1:0]   n_err;
  logic [S_W-1:0]   err_sum;
  logic [CNT_W-1:0] err_nxt;

  assign bus.q         = q_r;
  assign bus.ready     = ready_r;
  assign bus.hold_err  = hold_err_r;
  assign bus.ovf       = ovf_r;
  assign bus.err_count = err_r;

  // Edge detect, then per channel: release on the clock first, then hold check, then store or drop.
  always_comb begin
    pa        = bus.a ^ a_d;
    pc        = bus.rclk ^ rclk_d;
    // A clock pulse in this very cycle counts as zero cycles ago.
    eff_since = pc ? '0 : since_c;
    n_err     = '0;
    for (int i = 0; i < N; i++) begin
      rel[i]      = pc && (cnt[i] != '0);
      post_rel[i] = cnt[i] - C_W'(rel[i]);
      // Threshold follows the stored count before this cycle's release.
      herr[i]     = pa[i] && (eff_since < ((cnt[i] == '0) ? THR_E : THR_F));
      drop[i]     = pa[i] && (post_rel[i] >= DEPTH_C);
      cnt_nxt[i]  = post_rel[i] + C_W'(pa[i] && !drop[i]);
      n_err       = n_err + E_W'(herr[i]) + E_W'(drop[i]);
    end
    err_sum = S_W'(err_r) + S_W'(n_err);
    err_nxt = (|err_sum[S_W-1:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
  end

  // Input sample registers keep running through init so no stale edge appears when the bank arms.
  always_ff @(posedge clk) begin
    a_d    <= bus.a;
    rclk_d <= bus.rclk;
  end

  // Arm the bank BEGIN_CYC cycles after reset; stays armed until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      ready_r  <= 1'b0;
    end else if (!ready_r) begin
      init_cnt <= init_cnt + 1'b1;
      if (BEGIN_CYC == 0 || init_cnt == I_W'(BEGIN_CYC - 1))
        ready_r <= 1'b1;
    end
  end

  // Cycles since the last RSFQ clock pulse, saturating; starts saturated so the first pulse is clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      since_c <= SC_MAX;
    end else if (ready_r) begin
      if (pc)
        since_c <= '0;
      else if (since_c != SC_MAX)
        since_c <= since_c + 1'b1;
    end
  end

  // Channel storage, toggle outputs and sticky flags; reset discards any stored flux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      q_r        <= '0;
      hold_err_r <= '0;
      ovf_r      <= '0;
    end else if (ready_r) begin
      for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
      q_r        <= q_r ^ rel;
      hold_err_r <= hold_err_r | herr;
      ovf_r      <= ovf_r | drop;
    end
  end

  // Saturating total of hold violations and drops across all channels.
  always_ff @(posedge clk) begin
    if (rst)
      err_r <= '0;
    else if (ready_r)
      err_r <= err_nxt;
  end

endmodule

// File: tb/tb_rsfq_dfft_bank.sv
// Directed bench for the RSFQ DFFT bank: default bank, a DEPTH=3 bank and a CNT_W=2 bank.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: not applicable; every step is a fixed number of cycles.
module tb_rsfq_dfft_bank;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rsfq_dfft_bank_if #(.N(4), .CNT_W(16)) b0 ();
  rsfq_dfft_bank_if #(.N(4), .CNT_W(16)) b3 ();
  rsfq_dfft_bank_if #(.N(4), .CNT_W(2))  bs ();

  rsfq_dfft_bank u0 (.clk(clk), .rst(rst), .bus(b0));
  rsfq_dfft_bank #(.DEPTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  rsfq_dfft_bank #(.CNT_W(2)) us (.clk(clk), .rst(rst), .bus(bs));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    b0.a = '0; b0.rclk = 1'b0;
    b3.a = '0; b3.rclk = 1'b0;
    bs.a = '0; bs.rclk = 1'b0;
    tick(2);
    chk("rst_q",     b0.q, 0);
    chk("rst_ready", b0.ready, 0);
    chk("rst_flags", {b0.hold_err, b0.ovf}, 0);
    chk("rst_err",   b0.err_count, 0);

    // Init: pulses at cycles 3 and 5 are ignored, ready rises at cycle 8.
    rst = 1'b0;
    tick(2); b0.a[0] = ~b0.a[0]; tick(1);
    tick(1); b0.rclk = ~b0.rclk; tick(1);
    chk("init_ready_c5", b0.ready, 0);
    tick(2);
    chk("init_ready_c7", b0.ready, 0);
    tick(1);
    chk("init_ready_c8", b0.ready, 1);
    chk("init_q",        b0.q, 0);
    chk("init_err",      b0.err_count, 0);
    chk("init_hold",     b0.hold_err, 0);

    // Basic DFFT on channel 1.
    b0.a[1] = ~b0.a[1]; tick(5);
    chk("basic_q_before", b0.q, 4'b0000);
    b0.rclk = ~b0.rclk; tick(1);
    chk("basic_q1", b0.q, 4'b0010);
    b0.rclk = ~b0.rclk; tick(1);
    chk("basic_2nd_rclk", b0.q, 4'b0010);

    // Overflow on channel 2 with DEPTH=1.
    tick(4); b0.a[2] = ~b0.a[2]; tick(1);
    tick(4); b0.a[2] = ~b0.a[2]; tick(1);
    chk("ovf_flag", b0.ovf, 4'b0100);
    chk("ovf_err",  b0.err_count, 1);
    chk("ovf_hold", b0.hold_err, 0);
    b0.rclk = ~b0.rclk; tick(1);
    chk("ovf_release", b0.q, 4'b0110);

    // Hold violation on empty channel 0: data 2 cycles after rclk.
    tick(1); b0.a[0] = ~b0.a[0]; tick(1);
    chk("hold_empty_flag", b0.hold_err, 4'b0001);
    chk("hold_empty_err",  b0.err_count, 2);
    tick(3); b0.rclk = ~b0.rclk; tick(1);
    chk("hold_empty_stored", b0.q, 4'b0111);

    // Simultaneous data and clock on stored channel 1.
    tick(3); b0.a[1] = ~b0.a[1]; tick(1);
    tick(1); b0.a[1] = ~b0.a[1]; b0.rclk = ~b0.rclk; tick(1);
    chk("simul_q",    b0.q, 4'b0101);
    chk("simul_hold", b0.hold_err, 4'b0011);
    chk("simul_err",  b0.err_count, 3);
    chk("simul_ovf",  b0.ovf, 4'b0100);
    tick(3); b0.rclk = ~b0.rclk; tick(1);
    chk("simul_kept", b0.q, 4'b0111);

    // Reset while channel 3 holds a pulse.
    tick(3); b0.a[3] = ~b0.a[3]; tick(1);
    rst = 1'b1; tick(1);
    chk("mid_rst_q",     b0.q, 0);
    chk("mid_rst_flags", {b0.hold_err, b0.ovf}, 0);
    chk("mid_rst_err",   b0.err_count, 0);
    chk("mid_rst_ready", b0.ready, 0);
    rst = 1'b0;
    tick(7);
    chk("reinit_c7", b0.ready, 0);
    tick(1);
    chk("reinit_c8", b0.ready, 1);
    b0.rclk = ~b0.rclk; tick(1);
    chk("mid_rst_discard", b0.q, 0);

    // DEPTH=3: five pulses store three and drop two.
    for (int k = 0; k < 5; k++) begin
      b3.a[0] = ~b3.a[0]; tick(1);
    end
    chk("d3_ovf",  b3.ovf, 4'b0001);
    chk("d3_err",  b3.err_count, 2);
    chk("d3_hold", b3.hold_err, 0);
    b3.rclk = ~b3.rclk; tick(1);
    chk("d3_rel1", b3.q, 4'b0001);
    b3.rclk = ~b3.rclk; tick(1);
    chk("d3_rel2", b3.q, 4'b0000);
    b3.rclk = ~b3.rclk; tick(1);
    chk("d3_rel3", b3.q, 4'b0001);
    b3.rclk = ~b3.rclk; tick(1);
    chk("d3_empty", b3.q, 4'b0001);

    // DEPTH=3: data 2 cycles after rclk on a channel still holding a pulse uses HOLD_FULL.
    tick(3); b3.a[1] = ~b3.a[1]; tick(1);
    b3.a[1] = ~b3.a[1]; tick(1);
    b3.rclk = ~b3.rclk; tick(1);
    tick(1); b3.a[1] = ~b3.a[1]; tick(1);
    chk("hold_full_flag", b3.hold_err, 0);
    chk("hold_full_err",  b3.err_count, 2);
    chk("hold_full_q",    b3.q, 4'b0011);

    // CNT_W=2: five errors, two of them in one cycle, saturate at 3.
    bs.a[1] = ~bs.a[1]; bs.a[2] = ~bs.a[2]; tick(1);
    chk("sat_store", bs.err_count, 0);
    bs.a[1] = ~bs.a[1]; bs.a[2] = ~bs.a[2]; tick(1);
    chk("sat_multi", bs.err_count, 2);
    bs.a[1] = ~bs.a[1]; tick(1);
    chk("sat_3", bs.err_count, 3);
    bs.a[1] = ~bs.a[1]; tick(1);
    chk("sat_4", bs.err_count, 3);
    bs.a[2] = ~bs.a[2]; tick(1);
    chk("sat_5", bs.err_count, 3);
    chk("sat_ovf", bs.ovf, 4'b0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
